dmem_responder: RTL and testbench

Word-addressed data memory that acts as the responder for the CPU's MEM-stage load/store port. It accepts one request at a time over a valid/ready request channel and performs the array access after a fixed number of wait states. It returns the result over a valid/ready response channel. The CPU pipeline stalls on it through the handshakes, so both the fast (WAIT=0) and slow (WAIT>0) memory paths can be exercised.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 32-bit data memory serving a valid/ready
// load/store request channel and a valid/ready response channel.
// The array is accessed WAIT cycles after a request is accepted.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned addresses with rsp_err
// and suppress their array access; otherwise the low address bits are ignored.
module dmem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_idx;
    logic [DATA_W-1:0]    r_wdata;
    logic [3:0]           r_be;
    logic                 r_mis;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic                 w_in_mis;
    logic                 w_access;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_idx;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [3:0]           w_sel_be;
    logic                 w_sel_mis;
    logic                 w_unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_in_mis = (req_addr[1:0] != 2'b00);
`else
    assign w_in_mis = 1'b0;
`endif

    // Upper address bits wrap; byte-offset bits only matter for the align check.
    assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // With WAIT==0 the access happens on the acceptance edge, so use the live inputs.
    always_comb begin
        w_sel_we    = r_we;
        w_sel_idx   = r_idx;
        w_sel_wdata = r_wdata;
        w_sel_be    = r_be;
        w_sel_mis   = r_mis;
        if (r_state == ST_IDLE) begin
            w_sel_we    = req_we;
            w_sel_idx   = req_addr[ADDR_W+1:2];
            w_sel_wdata = req_wdata;
            w_sel_be    = req_be;
            w_sel_mis   = w_in_mis;
        end
    end

    // The array is touched exactly on the edge that enters RESP.
    assign w_access = !reset && (w_next == ST_RESP) && (r_state != ST_RESP);

    // Request capture and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_mis   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_we    <= req_we;
                r_idx   <= req_addr[ADDR_W+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_mis   <= w_in_mis;
                r_cnt   <= (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Byte-lane store into the array; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_access && w_sel_we && !w_sel_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel_be[i]) begin
                    r_mem[w_sel_idx][8*i +: 8] <= w_sel_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data and error, held until the response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (w_sel_we || w_sel_mis) ? '0 : r_mem[w_sel_idx];
            r_err   <= w_sel_mis;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_W=10, WAIT=2).
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WAIT   = 2;
    localparam int unsigned LAT    = WAIT + 1;
    localparam int unsigned TMO    = 20;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks;
    int n_errors;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, accept it, scramble inputs, and wait (bounded) for rsp_valid.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < TMO) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Full transaction: returns data and error, checks latency.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err);
        int lat;
        send(we, addr, wdata, be, lat);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        rdata = rsp_rdata;
        err   = rsp_err;
        finish_rsp();
    endtask

    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        // Full-word store then load.
        xfer("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        check("st_full_rdata", rd, 32'd0);
        check("st_full_err", 32'(er), 32'd0);
        xfer("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("ld_full_rdata", rd, 32'hDEADBEEF);

        // Partial store on lane 0.
        xfer("st_part", 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er);
        xfer("ld_part", 1'b0, 32'h10, 32'h0, 4'hF, rd, er);
        check("ld_part_rdata", rd, 32'hDEADBEAA);

        // Store with no byte enables leaves the word alone.
        xfer("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er);
        check("st_be0_rdata", rd, 32'd0);
        xfer("ld_be0", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("ld_be0_rdata", rd, 32'hDEADBEAA);

        // Address wrap: 0x1000 aliases word 0.
        xfer("st_wrap", 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er);
        xfer("ld_wrap", 1'b0, 32'h0000, 32'h0, 4'h0, rd, er);
        check("ld_wrap_rdata", rd, 32'h12345678);

        // Back-pressure with a competing request held on the input.
        send(1'b0, 32'h10, 32'h0, 4'h0, lat);
        check("bp_lat", 32'(lat), 32'(LAT));
        held = rsp_rdata;
        check("bp_rdata", held, 32'hDEADBEAA);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_rdata_hold", rsp_rdata, 32'hDEADBEAA);
            check("bp_ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_post_hs_ready", 32'(req_ready), 32'd1);
        check("bp_post_hs_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < TMO) begin
            tick();
            lat++;
        end
        check("bp_second_lat", 32'(lat), 32'(LAT));
        check("bp_second_rdata", rsp_rdata, 32'h12345678);
        finish_rsp();

        // Reset while in WAIT drops a pending store.
        xfer("st_prior", 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er);
        xfer("ld_prior", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("ld_prior_rdata", rd, 32'h11111111);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h00000055;
        req_be    = 4'hF;
        tick();
        req_valid = 1'b0;
        check("rw_in_wait", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("rw_req_ready", 32'(req_ready), 32'd1);
        check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw_rdata", rsp_rdata, 32'd0);
        repeat (4) tick();
        reset = 1'b0;
        tick();
        xfer("ld_after_rw", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("ld_after_rw_rdata", rd, 32'h11111111);

        // Reset while in RESP: the store already committed.
        send(1'b1, 32'h24, 32'h00000077, 4'hF, lat);
        check("rr_lat", 32'(lat), 32'(LAT));
        reset = 1'b1;
        #1;
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_req_ready", 32'(req_ready), 32'd1);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        xfer("ld_after_rr", 1'b0, 32'h24, 32'h0, 4'h0, rd, er);
        check("ld_after_rr_rdata", rd, 32'h00000077);

        // Misaligned load and store.
        xfer("ld_mis", 1'b0, 32'h13, 32'h0, 4'h0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        check("ld_mis_err", 32'(er), 32'd1);
        check("ld_mis_rdata", rd, 32'd0);
`else
        check("ld_mis_err", 32'(er), 32'd0);
        check("ld_mis_rdata", rd, 32'hDEADBEAA);
`endif
        xfer("st_mis", 1'b1, 32'h11, 32'h00000099, 4'hF, rd, er);
        xfer("ld_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        check("ld_after_mis_rdata", rd, 32'hDEADBEAA);
`else
        check("ld_after_mis_rdata", rd, 32'h00000099);
`endif
        check("ld_after_mis_err", 32'(er), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
